// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM states and
// default widths.
package alu_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_ADDR_W     = 10;
  localparam int DEFAULT_MUL_CYCLES = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_RUN
  } state_e;

  // Opcodes 11..15 are unassigned and produce a flagged zero result.
  function automatic logic is_illegal_op(logic [3:0] op);
    return op > OP_MUL;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Operand-in / result-out handshake bundle of the ALU execute stage.
// The slave modport is the stage itself; master is the register-file/writeback side.
interface alu_exec_stage_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [ADDR_W-1:0] dest_addr;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] result_addr;
  logic              zero_flag;
  logic              illegal_op;
  logic              busy;

  modport slave (
    input  in_valid, op, operand_a, operand_b, dest_addr, out_ready,
    output in_ready, out_valid, result, result_addr, zero_flag, illegal_op, busy
  );

  modport master (
    output in_valid, op, operand_a, operand_b, dest_addr, out_ready,
    input  in_ready, out_valid, result, result_addr, zero_flag, illegal_op, busy
  );

endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, low DATA_W
// bits of the product; done pulses together with the final product.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product_lo,
  output logic              busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

  logic              running;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] multiplicand;
  logic [DATA_W-1:0] multiplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;

  // The last iteration's sum is handed out directly so the product lands
  // exactly MUL_CYCLES edges after start.
  assign acc_next   = acc + (multiplier[0] ? multiplicand : '0);
  assign done       = running && (count == LAST);
  assign product_lo = acc_next;
  assign busy       = running;

  // NOTE: only the control bits are reset; the datapath registers are
  // always reloaded by start before they are used, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running      <= 1'b1;
      count        <= '0;
      multiplicand <= a;
      multiplier   <= b;
      acc          <= '0;
    end else if (running) begin
      acc          <= acc_next;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      count        <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL behind a valid/ready
// handshake, with a registered result/address output.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES
) (
  input logic              clk,
  input logic              rst,
  alu_exec_stage_if.slave  bus
);

  localparam int SH_W = $clog2(DATA_W);

  state_e            state;
  logic              out_valid_q;
  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] result_addr_q;
  logic              zero_q;
  logic              illegal_q;
  logic [ADDR_W-1:0] mul_addr;

  logic              accept;
  logic              start_mul;
  logic              mul_done;
  logic              mul_busy;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] alu_value;
  logic [SH_W-1:0]   shamt;

  // The output register may be refilled on the same edge it is drained.
  assign bus.in_ready = !rst && (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign start_mul    = accept && (bus.op == OP_MUL);
  assign shamt        = bus.operand_b[SH_W-1:0];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    alu_value = '0;
    case (bus.op)
      OP_ADD:  alu_value = bus.operand_a + bus.operand_b;
      OP_SUB:  alu_value = bus.operand_a - bus.operand_b;
      OP_AND:  alu_value = bus.operand_a & bus.operand_b;
      OP_OR:   alu_value = bus.operand_a | bus.operand_b;
      OP_XOR:  alu_value = bus.operand_a ^ bus.operand_b;
      OP_SLL:  alu_value = bus.operand_a << shamt;
      OP_SRL:  alu_value = bus.operand_a >> shamt;
      OP_SRA:  alu_value = $signed(bus.operand_a) >>> shamt;
      OP_SLT:  alu_value = {{(DATA_W-1){1'b0}}, $signed(bus.operand_a) < $signed(bus.operand_b)};
      OP_SLTU: alu_value = {{(DATA_W-1){1'b0}}, bus.operand_a < bus.operand_b};
      default: alu_value = '0;
    endcase
  end

  seq_multiplier #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (start_mul),
    .a          (bus.operand_a),
    .b          (bus.operand_b),
    .done       (mul_done),
    .product_lo (mul_product),
    .busy       (mul_busy)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      result_addr_q <= '0;
      zero_q        <= 1'b0;
      illegal_q     <= 1'b0;
      mul_addr      <= '0;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.op == OP_MUL) begin
              state    <= ST_MUL_RUN;
              mul_addr <= bus.dest_addr;
            end else begin
              out_valid_q   <= 1'b1;
              result_q      <= alu_value;
              result_addr_q <= bus.dest_addr;
              zero_q        <= (alu_value == '0);
              illegal_q     <= is_illegal_op(bus.op);
            end
          end
        end
        ST_MUL_RUN: begin
          // Acceptance required a drainable output, so it is empty here.
          if (mul_done) begin
            state         <= ST_IDLE;
            out_valid_q   <= 1'b1;
            result_q      <= mul_product;
            result_addr_q <= mul_addr;
            zero_q        <= (mul_product == '0);
            illegal_q     <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.result_addr = result_addr_q;
  assign bus.zero_flag   = zero_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.busy        = mul_busy;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus a random
// stream scored against a plain-arithmetic reference model.
module tb_alu_exec_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_exec_stage_if bus ();

  alu_exec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] result;
    logic [9:0]  addr;
    logic        zero;
    logic        illegal;
  } exp_t;

  function automatic logic [31:0] ref_result(int op, logic [31:0] a, logic [31:0] b);
    int unsigned s;
    s = b % 32;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << s;
      6:  return a >> s;
      7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return a * b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, int op, logic [31:0] a, logic [31:0] b, logic [9:0] d);
    bus.in_valid  = v;
    bus.op        = 4'(op);
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_addr = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++;
    if ({bus.out_valid, bus.result, bus.result_addr, bus.zero_flag, bus.illegal_op, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b res=%h addr=%h z=%b ill=%b busy=%b exp all 0",
               bus.out_valid, bus.result, bus.result_addr, bus.zero_flag, bus.illegal_op, bus.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_add_wrap();
    drive(1'b1, 0, 32'hFFFF_FFFF, 32'h1, 10'd5);
    step();
    drive(1'b0, 0, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h0 || bus.zero_flag !== 1'b1 || bus.result_addr !== 10'd5) begin
      errors++;
      $display("FAIL add_wrap got valid=%b res=%h z=%b addr=%0d exp valid=1 res=0 z=1 addr=5",
               bus.out_valid, bus.result, bus.zero_flag, bus.result_addr);
    end
  endtask

  task automatic test_back_to_back();
    int          ops [3]  = '{1, 7, 8};
    logic [31:0] as  [3]  = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [3]  = '{32'd7, 32'd4, 32'd1};
    logic [31:0] exps[3]  = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 10'(20 + i));
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exps[i] || bus.result_addr !== 10'(20 + i)) begin
        errors++;
        $display("FAIL b2b_result[%0d] got valid=%b res=%h addr=%0d exp valid=1 res=%h addr=%0d",
                 i, bus.out_valid, bus.result, bus.result_addr, exps[i], 20 + i);
      end
    end
    drive(1'b0, 0, 0, 0, 0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid=%b exp=0", bus.out_valid); end
  endtask

  task automatic run_mul(logic [31:0] a, logic [31:0] b, logic [9:0] d, string tag);
    int bad_wait = 0;
    drive(1'b1, 10, a, b, d);
    step();
    drive(1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad_wait++;
      step();
    end
    checks++;
    if (bad_wait != 0) begin errors++; $display("FAIL %s_wait got bad_cycles=%0d exp=0", tag, bad_wait); end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.result !== ref_result(10, a, b) || bus.result_addr !== d) begin
      errors++;
      $display("FAIL %s_result got valid=%b busy=%b res=%h addr=%0d exp valid=1 busy=0 res=%h addr=%0d",
               tag, bus.out_valid, bus.busy, bus.result, bus.result_addr, ref_result(10, a, b), d);
    end
    step();
  endtask

  task automatic test_mul();
    run_mul(32'h0001_2345, 32'h10, 10'd9, "mul_small");
    checks++;
    if (ref_result(10, 32'h0001_2345, 32'h10) !== 32'h0012_3450) begin errors++; $display("FAIL mul_model got=%h exp=00123450", ref_result(10, 32'h0001_2345, 32'h10)); end
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10'd1023, "mul_ones");
  endtask

  task automatic test_backpressure();
    int bad_hold = 0;
    bus.out_ready = 1'b0;
    drive(1'b1, 2, 32'hF0F0_1234, 32'h0FF0_FF00, 10'd44);
    step();
    drive(1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h00F0_1200 || bus.result_addr !== 10'd44 || bus.in_ready !== 1'b0)
        bad_hold++;
      step();
    end
    checks++;
    if (bad_hold != 0) begin errors++; $display("FAIL bp_hold got bad_cycles=%0d exp=0", bad_hold); end
    drive(1'b1, 3, 32'h0000_00F0, 32'h0000_000F, 10'd45);
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    step();
    drive(1'b0, 0, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'hFF || bus.result_addr !== 10'd45) begin
      errors++;
      $display("FAIL bp_refill got valid=%b res=%h addr=%0d exp valid=1 res=ff addr=45",
               bus.out_valid, bus.result, bus.result_addr);
    end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int stale = 0;
    drive(1'b1, 10, 32'd3, 32'd7, 10'd77);
    step();
    drive(1'b0, 0, 0, 0, 0);
    repeat (15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_mul got valid=%b busy=%b in_ready=%b exp 0 0 1", bus.out_valid, bus.busy, bus.in_ready);
    end
    repeat (40) begin
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stale++;
      step();
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL rst_stale got bad_cycles=%0d exp=0", stale); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 13, 32'hDEAD_BEEF, 32'h1234_5678, 10'd3);
    step();
    drive(1'b0, 0, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h0 || bus.illegal_op !== 1'b1 || bus.zero_flag !== 1'b1) begin
      errors++;
      $display("FAIL illegal got valid=%b res=%h ill=%b z=%b exp 1 0 1 1",
               bus.out_valid, bus.result, bus.illegal_op, bus.zero_flag);
    end
    step();
  endtask

  task automatic test_random_stream();
    exp_t        q[$];
    exp_t        e;
    exp_t        got;
    int          sent = 0;
    int          done = 0;
    int          cycles = 0;
    int          n = 150;
    logic        pending = 1'b0;
    int          op;
    logic [31:0] a, b;
    logic [9:0]  d;
    while ((sent < n || q.size() != 0) && cycles < 20000) begin
      if (!pending && sent < n) begin
        op = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 15));
        a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        d  = 10'($urandom);
        pending = 1'b1;
      end
      drive(pending, op, a, b, d);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        got = '{bus.result, bus.result_addr, bus.zero_flag, bus.illegal_op};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_unexpected got res=%h addr=%0d exp no output", got.result, got.addr);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL rnd_result[%0d] got res=%h addr=%0d z=%b ill=%b exp res=%h addr=%0d z=%b ill=%b",
                     done, got.result, got.addr, got.zero, got.illegal, e.result, e.addr, e.zero, e.illegal);
          end
          done++;
        end
      end
      if (pending && bus.in_ready === 1'b1) begin
        e.result  = ref_result(op, a, b);
        e.addr    = d;
        e.zero    = (e.result == 32'h0);
        e.illegal = (op > 10);
        q.push_back(e);
        pending = 1'b0;
        sent++;
      end
      step();
      cycles++;
    end
    drive(1'b0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    checks++;
    if (done != n) begin errors++; $display("FAIL rnd_timeout got completed=%0d exp=%0d", done, n); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_illegal();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
